// File: rtl/jtframe_neptuno_pkg.sv
// Shared constants for the Neptuno key sequencer: key codes, idle/wait bytes,
// FSM state encodings and the event arbitration helpers.
package jtframe_neptuno_pkg;

    localparam logic [7:0] CODE_IDLE = 8'hFF;
    localparam logic [7:0] CODE_WAIT = 8'h3F;
    localparam logic [7:0] CODE_OSD  = 8'h7F;
    localparam logic [7:0] CODE_R    = 8'hF7;
    localparam logic [7:0] CODE_L    = 8'hFB;
    localparam logic [7:0] CODE_D    = 8'hFD;
    localparam logic [7:0] CODE_U    = 8'hFE;
    localparam logic [7:0] CODE_FIRE = 8'hEF;

    // Event vector order is also the priority order: bit 0 wins.
    localparam int NEV    = 6;
    localparam int EV_OSD = 0;
    localparam int EV_R   = 1;
    localparam int EV_L   = 2;
    localparam int EV_D   = 3;
    localparam int EV_U   = 4;
    localparam int EV_FIRE = 5;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_WAIT,
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    function automatic logic [NEV-1:0] first_set(input logic [NEV-1:0] v);
        return v & (~v + NEV'(1));
    endfunction

    function automatic logic [7:0] ev_code(input logic [NEV-1:0] grant);
        logic [7:0] code;
        code = CODE_IDLE;
        if (grant[EV_OSD])       code = CODE_OSD;
        else if (grant[EV_R])    code = CODE_R;
        else if (grant[EV_L])    code = CODE_L;
        else if (grant[EV_D])    code = CODE_D;
        else if (grant[EV_U])    code = CODE_U;
        else if (grant[EV_FIRE]) code = CODE_FIRE;
        return code;
    endfunction

endpackage

// File: rtl/jtframe_neptuno_linecnt.sv
// Saturating line counter: clears on clr, otherwise advances once per cen
// pulse and sticks at all-ones instead of wrapping.
module jtframe_neptuno_linecnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cen,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cen && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/jtframe_neptuno_keyseq.sv
// Turns joystick/OSD events into timed key codes for the Neptuno SPI data_io.
// Auto-repeat of held direction keys is built only with JTFRAME_NEPTUNO_KEYRPT_EN.
module jtframe_neptuno_keyseq
    import jtframe_neptuno_pkg::*;
#(
    parameter int BOOT_CYC   = 65535,
    parameter int HOLD_LINES = 4,
    parameter int GAP_LINES  = 4,
    parameter int RPT_DLY    = 30,
    parameter int RPT_RATE   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        dwn_start,
    input  logic [11:0] joy_mix,
    input  logic        osd_req,
    output logic [7:0]  nept_din,
    output logic        busy
);

    localparam int BW = $clog2(BOOT_CYC + 1);
    localparam int LW = $clog2((HOLD_LINES > GAP_LINES ? HOLD_LINES : GAP_LINES) + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);
    localparam logic [LW-1:0] HOLD_LAST = LW'(HOLD_LINES - 1);
    localparam logic [LW-1:0] GAP_LAST  = LW'(GAP_LINES - 1);

    state_e          state_d, state_q;
    logic [BW-1:0]   boot_cnt_d, boot_cnt_q;
    logic            ready_d, ready_q;
    logic [4:0]      joy_prev_d, joy_prev_q;
    logic            osd_prev_d, osd_prev_q;
    logic [NEV-1:0]  pend_d, pend_q;
    logic [7:0]      code_d, code_q;
    logic [NEV-1:0]  edges, ticks, grant;
    logic [LW-1:0]   line_cnt;
    logic            line_clr;
    logic            unused_ok;

    assign unused_ok = ^joy_mix[11:5];

    // Event bit 0 is the OSD request, bits 1..5 follow joy_mix[0..4].
    always_comb begin
        joy_prev_d = joy_mix[4:0];
        osd_prev_d = osd_req;
        ready_d    = ready_q | dwn_start;
        edges      = {joy_mix[4:0] & ~joy_prev_q, osd_req & ~osd_prev_q};
        grant      = (state_q == ST_IDLE) ? first_set(pend_q) : '0;
        pend_d     = (pend_q & ~grant) | edges | ticks;
    end

`ifdef JTFRAME_NEPTUNO_KEYRPT_EN
    localparam int RW = $clog2((RPT_DLY > RPT_RATE ? RPT_DLY : RPT_RATE) + 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(RPT_DLY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(RPT_RATE - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first_d, rpt_first_q;
    logic          single_dir, joy_stable, rpt_tick, rpt_clr;

    always_comb begin
        single_dir  = (joy_mix[3:0] != 4'd0) &&
                      ((joy_mix[3:0] & (joy_mix[3:0] - 4'd1)) == 4'd0);
        joy_stable  = (joy_mix[4:0] == joy_prev_q);
        rpt_tick    = single_dir && joy_stable && cen &&
                      (rpt_cnt == (rpt_first_q ? DLY_LAST : RATE_LAST));
        rpt_clr     = !single_dir || !joy_stable || rpt_tick;
        rpt_first_d = rpt_first_q;
        if (!single_dir || !joy_stable) begin
            rpt_first_d = 1'b1;
        end else if (rpt_tick) begin
            rpt_first_d = 1'b0;
        end
        ticks = {1'b0, joy_mix[3:0] & {4{rpt_tick}}, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_first_q <= 1'b1;
        end else begin
            rpt_first_q <= rpt_first_d;
        end
    end

    jtframe_neptuno_linecnt #(.W(RW)) u_rpt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rpt_clr),
        .cen   (cen),
        .cnt   (rpt_cnt)
    );
`else
    localparam int unused_rpt_cfg = RPT_DLY + RPT_RATE;
    assign ticks = '0;
`endif

    // The line counter restarts on every state change, so a cen seen on the
    // first cycle of SEND or GAP already counts toward that state.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        code_d     = code_q;
        nept_din   = CODE_IDLE;
        busy       = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + BW'(1);
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ready_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                nept_din = CODE_WAIT;
                if (ready_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (|grant) begin
                    code_d  = ev_code(grant);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                nept_din = code_q;
                busy     = 1'b1;
                if (cen && (line_cnt == HOLD_LAST)) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (cen && (line_cnt == GAP_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        line_clr = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            ready_q    <= 1'b0;
            joy_prev_q <= '0;
            osd_prev_q <= 1'b0;
            pend_q     <= '0;
            code_q     <= CODE_IDLE;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            ready_q    <= ready_d;
            joy_prev_q <= joy_prev_d;
            osd_prev_q <= osd_prev_d;
            pend_q     <= pend_d;
            code_q     <= code_d;
        end
    end

    jtframe_neptuno_linecnt #(.W(LW)) u_line_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (line_clr),
        .cen   (cen),
        .cnt   (line_cnt)
    );

endmodule

// File: tb/tb_jtframe_neptuno_keyseq.sv
// Directed bench for jtframe_neptuno_keyseq with BOOT_CYC=16; repeat
// expectations follow JTFRAME_NEPTUNO_KEYRPT_EN.
module tb_jtframe_neptuno_keyseq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        dwn_start;
    logic [11:0] joy_mix;
    logic        osd_req;
    logic [7:0]  nept_din;
    logic        busy;

    int compared = 0;
    int mismatched = 0;
    int cen_count = 0;

    logic       fd_mon = 1'b0;
    int         fd_seen = 0;
    int         fd_at [8];
    int         d_base = 0;
    logic [7:0] din_prev = 8'hFF;

    always #5 clk = ~clk;

    jtframe_neptuno_keyseq #(
        .BOOT_CYC   (16),
        .HOLD_LINES (4),
        .GAP_LINES  (4),
        .RPT_DLY    (30),
        .RPT_RATE   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .dwn_start (dwn_start),
        .joy_mix   (joy_mix),
        .osd_req   (osd_req),
        .nept_din  (nept_din),
        .busy      (busy)
    );

    // Line-rate enable: one clk high out of every four.
    initial begin
        int ph;
        ph = 0;
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cen = (ph == 0);
            if (ph == 0) cen_count = cen_count + 1;
            ph = (ph + 1) % 4;
        end
    end

    // Records the line index (relative to d_base) at which each D code begins.
    always @(negedge clk) begin
        if (fd_mon && nept_din == 8'hFD && din_prev != 8'hFD && fd_seen < 8) begin
            fd_at[fd_seen] <= cen_count - d_base;
            fd_seen <= fd_seen + 1;
        end
        din_prev <= nept_din;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] joy, input logic osd, input logic dwn);
        @(posedge clk);
        #2;
        joy_mix   = joy;
        osd_req   = osd;
        dwn_start = dwn;
    endtask

    task automatic waitBusy(input logic lvl, input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (busy !== lvl && g < 400) begin
            @(negedge clk);
            g++;
        end
        checkOutput(tag, {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic measureSend(input string tag, input logic [7:0] exp_code);
        logic [7:0] code;
        int hold, gap, busy_cen, g;
        waitBusy(1'b1, {tag, "_start"});
        code = nept_din;
        hold = 0;
        gap = 0;
        busy_cen = 0;
        g = 0;
        while (busy === 1'b1 && g < 400) begin
            if (cen) begin
                busy_cen++;
                if (nept_din == code) hold++;
                else if (nept_din == 8'hFF) gap++;
            end
            @(negedge clk);
            g++;
        end
        checkOutput({tag, "_code"}, {24'd0, code}, {24'd0, exp_code});
        checkOutput({tag, "_hold"}, hold, 4);
        checkOutput({tag, "_gap"}, gap, 4);
        checkOutput({tag, "_busy"}, busy_cen, 8);
    endtask

    task automatic checkBoot(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput({tag, "_ff"}, {24'd0, nept_din}, 32'hFF);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput({tag, "_wait"}, {24'd0, nept_din}, 32'h3F);
        end
    endtask

    initial begin
        int g, extra;
        rst_n = 1'b0;
        dwn_start = 1'b0;
        joy_mix = '0;
        osd_req = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_din", {24'd0, nept_din}, 32'hFF);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkBoot("boot1");
        repeat (20) @(negedge clk);
        checkOutput("wait_stays", {24'd0, nept_din}, 32'h3F);

        applyStimulus(12'h000, 1'b0, 1'b1);
        applyStimulus(12'h000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("idle_din", {24'd0, nept_din}, 32'hFF);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        applyStimulus(12'h001, 1'b0, 1'b0);
        measureSend("r", 8'hF7);
        applyStimulus(12'h000, 1'b0, 1'b0);

        applyStimulus(12'h008, 1'b1, 1'b0);
        measureSend("osd", 8'h7F);
        measureSend("u", 8'hFE);
        applyStimulus(12'h000, 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cen !== 1'b1 && g < 16);
        applyStimulus(12'h004, 1'b0, 1'b0);
        d_base = cen_count;
        fd_mon = 1'b1;
        g = 0;
        while ((cen_count - d_base) < 60 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        applyStimulus(12'h000, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        fd_mon = 1'b0;
        checkOutput("d_first", fd_at[0], 0);
`ifdef JTFRAME_NEPTUNO_KEYRPT_EN
        checkOutput("d_count", fd_seen, 5);
        checkOutput("d_rpt1", fd_at[1], 30);
        checkOutput("d_rpt2", fd_at[2], 38);
        checkOutput("d_rpt3", fd_at[3], 46);
        checkOutput("d_rpt4", fd_at[4], 54);
`else
        checkOutput("d_count", fd_seen, 1);
`endif

        applyStimulus(12'h010, 1'b0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (nept_din !== 8'hEF && g < 200);
        checkOutput("fire_send", {24'd0, nept_din}, 32'hEF);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        joy_mix = '0;
        #1;
        checkOutput("rst_mid_din", {24'd0, nept_din}, 32'hFF);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkBoot("boot2");

        applyStimulus(12'h000, 1'b0, 1'b1);
        applyStimulus(12'h000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("idle2_din", {24'd0, nept_din}, 32'hFF);

        applyStimulus(12'h001, 1'b0, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(busy === 1'b1 && nept_din === 8'hFF) && g < 200);
        checkOutput("tap_in_gap", {24'd0, nept_din}, 32'hFF);
        applyStimulus(12'h002, 1'b0, 1'b0);
        applyStimulus(12'h000, 1'b0, 1'b0);
        waitBusy(1'b0, "gap_end");
        measureSend("l_tap", 8'hFB);
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0) extra++;
        end
        checkOutput("l_once", extra, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
